// File: rtl/ab_alu_datapath.sv
// A/B accumulator registers and 4-function ALU of the SAP-style CPU.
// All state is strobe-driven by the control sequencer; flags hold between ALU ops for JZ.
module ab_alu_datapath #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   opcode,
  input  logic [W-1:0] ram_in,
  input  logic [W-1:0] tmp_in,
  input  logic         carry_in,
  input  logic         la_ram,
  input  logic         la_b,
  input  logic         la_alu,
  input  logic         lb_tmp,
  input  logic         lb_alu,
  input  logic         eu,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         z,
  output logic         cy
);

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_XCHG = 4'b0011;
  localparam logic [3:0] OP_RCL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;

  logic [W-1:0] a_d, b_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  logic         z_q, z_d;
  logic         cy_q, cy_d;
  logic [W:0]   sum_c;
  logic [W-1:0] diff_c;
  logic [W-1:0] shr_c;
  logic [W-1:0] rcl_c;

  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign z     = z_q;
  assign cy    = cy_q;

  // Candidate ALU results from the pre-edge register values
  always_comb begin
    sum_c  = {1'b0, a_q} + {1'b0, b_q};
    diff_c = a_q - b_q;
    shr_c  = {1'b0, a_q[W-1:1]};
    rcl_c  = {b_q[W-2:0], carry_in};
  end

  // A/B load muxes; la_b reads b_q before the edge so a same-edge swap is clean
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (la_alu)      a_d = alu_a_q;
    else if (la_b)   a_d = b_q;
    else if (la_ram) a_d = ram_in;
    if (lb_alu)      b_d = alu_b_q;
    else if (lb_tmp) b_d = tmp_in;
  end

  // ALU result/flag registers update only on eu with an ALU opcode
  always_comb begin
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    z_d     = z_q;
    cy_d    = cy_q;
    if (eu) begin
      case (opcode)
        OP_ADD: begin
          alu_a_d = sum_c[W-1:0];
          cy_d    = sum_c[W];
          z_d     = (sum_c[W-1:0] == '0);
        end
        OP_SUB: begin
          alu_a_d = diff_c;
          cy_d    = (a_q < b_q);
          z_d     = (diff_c == '0);
        end
        OP_SHR: begin
          alu_a_d = shr_c;
          cy_d    = a_q[0];
          z_d     = (shr_c == '0);
        end
        OP_RCL: begin
          alu_b_d = rcl_c;
          cy_d    = b_q[W-1];
          z_d     = (rcl_c == '0);
        end
        OP_XCHG: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      z_q     <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      z_q     <= z_d;
      cy_q    <= cy_d;
    end
  end

endmodule

// File: tb/tb_ab_alu_datapath.sv
// Directed bench for ab_alu_datapath: integer-arithmetic reference model compared every cycle,
// plus hand-computed literal checks of the key instruction sequences.
module tb_ab_alu_datapath;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [3:0] ram_in, tmp_in;
  logic       carry_in;
  logic       la_ram, la_b, la_alu, lb_tmp, lb_alu, eu;
  logic [3:0] a_q, b_q, alu_a, alu_b;
  logic       z, cy;

  int n_tests;
  int n_fail;

  // Reference state kept as plain integers 0..15 and 0/1
  int m_a, m_b, m_ra, m_rb, m_z, m_cy;

  ab_alu_datapath #(.W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ram_in(ram_in), .tmp_in(tmp_in),
    .carry_in(carry_in), .la_ram(la_ram), .la_b(la_b), .la_alu(la_alu),
    .lb_tmp(lb_tmp), .lb_alu(lb_alu), .eu(eu), .a_q(a_q), .b_q(b_q),
    .alu_a(alu_a), .alu_b(alu_b), .z(z), .cy(cy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: ALU ops from the arithmetic definitions, loads by stated priority
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a <= 0; m_b <= 0; m_ra <= 0; m_rb <= 0; m_z <= 0; m_cy <= 0;
    end else begin
      if (eu) begin
        case (opcode)
          4'd1: begin
            m_ra <= (m_a + m_b) % 16;
            m_cy <= (m_a + m_b >= 16) ? 1 : 0;
            m_z  <= ((m_a + m_b) % 16 == 0) ? 1 : 0;
          end
          4'd2: begin
            m_ra <= (m_a - m_b + 16) % 16;
            m_cy <= (m_a < m_b) ? 1 : 0;
            m_z  <= (m_a == m_b) ? 1 : 0;
          end
          4'd5: begin
            m_ra <= m_a / 2;
            m_cy <= m_a % 2;
            m_z  <= (m_a / 2 == 0) ? 1 : 0;
          end
          4'd4: begin
            m_rb <= (m_b * 2 + int'(carry_in)) % 16;
            m_cy <= (m_b >= 8) ? 1 : 0;
            m_z  <= ((m_b * 2 + int'(carry_in)) % 16 == 0) ? 1 : 0;
          end
          default: ;
        endcase
      end
      if (la_alu)      m_a <= m_ra;
      else if (la_b)   m_a <= m_b;
      else if (la_ram) m_a <= int'(ram_in);
      if (lb_alu)      m_b <= m_rb;
      else if (lb_tmp) m_b <= int'(tmp_in);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    n_tests++;
    if (int'(a_q) != m_a || int'(b_q) != m_b || int'(alu_a) != m_ra ||
        int'(alu_b) != m_rb || int'(z) != m_z || int'(cy) != m_cy) begin
      n_fail++;
      $display("FAIL model t=%0t: dut a=%0d b=%0d ra=%0d rb=%0d z=%0d cy=%0d, want a=%0d b=%0d ra=%0d rb=%0d z=%0d cy=%0d",
               $time, a_q, b_q, alu_a, alu_b, z, cy, m_a, m_b, m_ra, m_rb, m_z, m_cy);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    la_ram = 0; la_b = 0; la_alu = 0; lb_tmp = 0; lb_alu = 0; eu = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 0; opcode = 0; ram_in = 0; tmp_in = 0; carry_in = 0;
    clr();
    tick(); tick();
    chk("reset_a", a_q, 4'd0);
    chk("reset_cy", {3'b0, cy}, 4'd0);
    reset = 1;

    // Mid-run async reset with A=B=5
    ram_in = 4'd5; tmp_in = 4'd5; la_ram = 1; lb_tmp = 1; tick(); clr();
    chk("load5_a", a_q, 4'd5);
    chk("load5_b", b_q, 4'd5);
    #2 reset = 0;
    #1;
    chk("async_rst_a", a_q, 4'd0);
    chk("async_rst_b", b_q, 4'd0);
    ram_in = 4'd9; la_ram = 1; lb_tmp = 1; eu = 1; opcode = 4'd1;
    tick();
    chk("rst_hold_a", a_q, 4'd0);
    chk("rst_hold_z", {3'b0, z}, 4'd0);
    clr(); reset = 1; tick();

    // SUB equal operands -> zero
    ram_in = 4'b1011; tmp_in = 4'b1011; la_ram = 1; lb_tmp = 1; tick(); clr();
    opcode = 4'b0010; eu = 1; tick(); clr();
    la_alu = 1; tick(); clr();
    chk("sub_a", a_q, 4'b0000);
    chk("sub_z", {3'b0, z}, 4'd1);
    chk("sub_cy", {3'b0, cy}, 4'd0);

    // ADD with carry out
    la_ram = 1; tick(); clr();
    opcode = 4'b0001; eu = 1; tick(); clr();
    la_alu = 1; tick(); clr();
    chk("add_a", a_q, 4'b0110);
    chk("add_cy", {3'b0, cy}, 4'd1);
    chk("add_z", {3'b0, z}, 4'd0);

    // SHR A, then RCL B
    la_ram = 1; tick(); clr();
    opcode = 4'b0101; eu = 1; tick(); clr();
    la_alu = 1; tick(); clr();
    chk("shr_a", a_q, 4'b0101);
    chk("shr_cy", {3'b0, cy}, 4'd1);
    carry_in = 1; opcode = 4'b0100; eu = 1; tick(); clr();
    lb_alu = 1; tick(); clr();
    chk("rcl_b", b_q, 4'b0111);
    chk("rcl_cy", {3'b0, cy}, 4'd1);

    // Same-edge swap
    ram_in = 4'b1011; tmp_in = 4'b0010; la_ram = 1; lb_tmp = 1; tick(); clr();
    tmp_in = 4'b1011; la_b = 1; lb_tmp = 1; tick(); clr();
    chk("swap_a", a_q, 4'b0010);
    chk("swap_b", b_q, 4'b1011);

    // Load priority; non-ALU opcode holds flags
    ram_in = 4'hF; la_alu = 1; la_b = 1; la_ram = 1; lb_alu = 1; lb_tmp = 1; tick(); clr();
    chk("prio_a", a_q, 4'b0101);
    chk("prio_b", b_q, 4'b0111);
    opcode = 4'b1011; eu = 1; tick(); clr();
    chk("nonalu_z", {3'b0, z}, 4'd0);
    chk("nonalu_cy", {3'b0, cy}, 4'd1);

    // la_alu on the eu edge takes the previous result
    ram_in = 4'd3; tmp_in = 4'd1; la_ram = 1; lb_tmp = 1; tick(); clr();
    opcode = 4'b0001; eu = 1; la_alu = 1; tick(); clr();
    chk("stale_a", a_q, 4'b0101);
    chk("stale_alu_a", alu_a, 4'd4);

    // Wrap boundaries: 2-5 borrow, 15+1 zero+carry, RCL of 0
    ram_in = 4'd2; tmp_in = 4'd5; la_ram = 1; lb_tmp = 1; tick(); clr();
    opcode = 4'b0010; eu = 1; tick(); clr();
    chk("sub_wrap", alu_a, 4'd13);
    chk("sub_borrow", {3'b0, cy}, 4'd1);
    ram_in = 4'd15; tmp_in = 4'd1; la_ram = 1; lb_tmp = 1; tick(); clr();
    opcode = 4'b0001; eu = 1; tick(); clr();
    chk("add_wrap", alu_a, 4'd0);
    chk("add_wrap_z", {3'b0, z}, 4'd1);
    tmp_in = 4'd0; lb_tmp = 1; tick(); clr();
    carry_in = 0; opcode = 4'b0100; eu = 1; tick(); clr();
    chk("rcl_zero_b", alu_b, 4'd0);
    chk("rcl_zero_z", {3'b0, z}, 4'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
